// File: rtl/pattern_dead_time.sv
// CLCT dead-time filter: fires the best pattern candidate unless a recent fire
// nearby in key space is still within its blanking window.
module pattern_dead_time #(
    parameter int MXPATB = 7,
    parameter int MXKEYB = 5,
    parameter int MXPATC = 12
) (
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              best_vld,
    input  logic [MXPATB-1:0] best_pat,
    input  logic [MXKEYB-1:0] best_key,
    input  logic [MXPATC-1:0] best_carry,
    input  logic [2:0]        hit_thresh,
    input  logic [3:0]        pid_thresh,
    input  logic [3:0]        dead_time,
    input  logic [2:0]        dead_zone,
    output logic              clct_vld,
    output logic [MXPATB-1:0] clct_pat,
    output logic [MXKEYB-1:0] clct_key,
    output logic [MXPATC-1:0] clct_carry,
    output logic              busy,
    output logic [15:0]       clct_cnt,
    output logic [15:0]       blank_cnt,
    output logic              fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        dead_cnt;
    logic [MXKEYB-1:0] zone_key;

    logic              qualify;
    logic [MXKEYB-1:0] key_diff;
    logic              in_zone;
    logic              blank;
    logic              fire;

    // Absolute key distance: keys never wrap, so 31 and 0 are far apart.
    always_comb begin
        qualify  = best_vld
                   && (best_pat[MXPATB-1 -: 3] >= hit_thresh)
                   && (best_pat[3:0] >= pid_thresh);
        key_diff = (best_key >= zone_key) ? (best_key - zone_key)
                                          : (zone_key - best_key);
        in_zone  = key_diff <= MXKEYB'(dead_zone);
        blank    = qualify && (state == DEAD) && in_zone;
        fire     = qualify && !blank;
    end

    assign fsm_state = (state == DEAD);

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state      <= IDLE;
            dead_cnt   <= 4'd0;
            zone_key   <= '0;
            busy       <= 1'b0;
            clct_vld   <= 1'b0;
            clct_pat   <= '0;
            clct_key   <= '0;
            clct_carry <= '0;
            clct_cnt   <= 16'd0;
            blank_cnt  <= 16'd0;
        end else begin
            clct_vld <= fire;
            if (fire) begin
                clct_pat   <= best_pat;
                clct_key   <= best_key;
                clct_carry <= best_carry;
            end
            if (fire && (clct_cnt != 16'hFFFF)) begin
                clct_cnt <= clct_cnt + 16'd1;
            end
            if (blank && (blank_cnt != 16'hFFFF)) begin
                blank_cnt <= blank_cnt + 16'd1;
            end

            // Any fire (re)arms the single tracked zone; dead_time only read here.
            if (fire) begin
                if (dead_time != 4'd0) begin
                    state    <= DEAD;
                    busy     <= 1'b1;
                    zone_key <= best_key;
                    dead_cnt <= dead_time;
                end else begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    dead_cnt <= 4'd0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    DEAD: begin
                        if (dead_cnt <= 4'd1) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            dead_cnt <= 4'd0;
                        end else begin
                            busy     <= 1'b1;
                            dead_cnt <= dead_cnt - 4'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        dead_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_dead_time.sv
// Bench for pattern_dead_time: vector table through a scoreboard queue,
// then saturation and asynchronous-reset sequences.
module tb_pattern_dead_time;

    localparam int W = 1 + 7 + 5 + 12 + 1 + 16 + 16;

    logic        clock;
    logic        global_reset_n;
    logic        best_vld;
    logic [6:0]  best_pat;
    logic [4:0]  best_key;
    logic [11:0] best_carry;
    logic [2:0]  hit_thresh;
    logic [3:0]  pid_thresh;
    logic [3:0]  dead_time;
    logic [2:0]  dead_zone;
    logic        clct_vld;
    logic [6:0]  clct_pat;
    logic [4:0]  clct_key;
    logic [11:0] clct_carry;
    logic        busy;
    logic [15:0] clct_cnt;
    logic [15:0] blank_cnt;
    logic        fsm_state;

    pattern_dead_time dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .best_vld       (best_vld),
        .best_pat       (best_pat),
        .best_key       (best_key),
        .best_carry     (best_carry),
        .hit_thresh     (hit_thresh),
        .pid_thresh     (pid_thresh),
        .dead_time      (dead_time),
        .dead_zone      (dead_zone),
        .clct_vld       (clct_vld),
        .clct_pat       (clct_pat),
        .clct_key       (clct_key),
        .clct_carry     (clct_carry),
        .busy           (busy),
        .clct_cnt       (clct_cnt),
        .blank_cnt      (blank_cnt),
        .fsm_state      (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        vld;
        logic [6:0]  pat;
        logic [4:0]  key;
        logic [3:0]  dt;
        logic [2:0]  dz;
        logic        e_vld;
        logic        e_busy;
        logic [15:0] e_ccnt;
        logic [15:0] e_bcnt;
    } vec_t;

    vec_t           vecs[$];
    logic [W-1:0]   exp_q[$];
    int             total = 0;
    int             bad = 0;
    logic [6:0]     last_pat = '0;
    logic [4:0]     last_key = '0;
    logic [11:0]    last_carry = '0;

    function automatic logic [W-1:0] actual_word();
        return {clct_vld, clct_pat, clct_key, clct_carry, busy, clct_cnt, blank_cnt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic vld, input logic [6:0] pat, input logic [4:0] key,
                           input logic [3:0] dt, input logic [2:0] dz, input logic e_vld,
                           input logic e_busy, input int e_ccnt, input int e_bcnt);
        vec_t v;
        v.vld = vld; v.pat = pat; v.key = key; v.dt = dt; v.dz = dz;
        v.e_vld = e_vld; v.e_busy = e_busy;
        v.e_ccnt = 16'(e_ccnt); v.e_bcnt = 16'(e_bcnt);
        vecs.push_back(v);
    endtask

    // driver: present a candidate, push expectation, pop and compare after the edge
    task automatic apply(input int idx);
        vec_t v;
        logic [W-1:0] exp_w;
        v = vecs[idx];
        best_vld   = v.vld;
        best_pat   = v.pat;
        best_key   = v.key;
        best_carry = {v.key, v.pat};
        dead_time  = v.dt;
        dead_zone  = v.dz;
        if (v.e_vld) begin
            last_pat   = v.pat;
            last_key   = v.key;
            last_carry = {v.key, v.pat};
        end
        exp_q.push_back({v.e_vld, last_pat, last_key, last_carry, v.e_busy, v.e_ccnt, v.e_bcnt});
        @(posedge clock);
        #1;
        exp_w = exp_q.pop_front();
        check($sformatf("vec%0d", idx), 64'(actual_word()), 64'(exp_w));
    endtask

    initial begin
        global_reset_n = 1'b0;
        best_vld = 1'b0; best_pat = '0; best_key = '0; best_carry = '0;
        hit_thresh = 3'd4; pid_thresh = 4'd2; dead_time = 4'd0; dead_zone = 3'd0;
        #12;
        check("reset_outputs", 64'(actual_word()), 64'd0);
        check("reset_state", 64'(fsm_state), 64'd0);
        global_reset_n = 1'b1;

        // thresholds, dead_time=0
        add_vec(1, 7'b100_0010, 10, 0, 0, 1, 0, 1, 0);
        add_vec(1, 7'b011_1000, 10, 0, 0, 0, 0, 1, 0);
        add_vec(1, 7'b100_0001, 10, 0, 0, 0, 0, 1, 0);
        add_vec(0, 7'b111_1111, 10, 0, 0, 0, 0, 1, 0);
        add_vec(1, 7'b111_1111,  3, 0, 0, 1, 0, 2, 0);
        // blanking window dead_time=5 dead_zone=2
        add_vec(1, 7'b100_0010, 10, 5, 2, 1, 1, 3, 0);
        add_vec(1, 7'b100_0010, 12, 5, 2, 0, 1, 3, 1);
        add_vec(1, 7'b100_0010, 12, 5, 2, 0, 1, 3, 2);
        add_vec(1, 7'b100_0010, 12, 5, 2, 0, 1, 3, 3);
        add_vec(1, 7'b100_0010, 12, 5, 2, 0, 1, 3, 4);
        add_vec(1, 7'b100_0010, 12, 5, 2, 0, 0, 3, 5);
        add_vec(1, 7'b100_0010, 12, 5, 2, 1, 1, 4, 5);
        // out-of-zone reload
        add_vec(0, 7'b100_0010, 12, 5, 2, 0, 1, 4, 5);
        add_vec(1, 7'b101_0011, 20, 5, 2, 1, 1, 5, 5);
        add_vec(1, 7'b110_0100, 10, 5, 2, 1, 1, 6, 5);
        add_vec(1, 7'b100_0010, 11, 5, 2, 0, 1, 6, 6);
        add_vec(0, 7'b100_0010, 10, 5, 2, 0, 1, 6, 6);
        add_vec(0, 7'b100_0010, 10, 5, 2, 0, 1, 6, 6);
        add_vec(0, 7'b100_0010, 10, 5, 2, 0, 1, 6, 6);
        add_vec(0, 7'b100_0010, 10, 5, 2, 0, 0, 6, 6);
        // key-edge clipping dead_zone=3
        add_vec(1, 7'b100_0010, 30, 5, 3, 1, 1, 7, 6);
        add_vec(1, 7'b100_0010, 31, 5, 3, 0, 1, 7, 7);
        add_vec(1, 7'b100_0010, 27, 5, 3, 0, 1, 7, 8);
        add_vec(1, 7'b100_0010,  0, 5, 3, 1, 1, 8, 8);
        add_vec(1, 7'b100_0010,  3, 5, 3, 0, 1, 8, 9);
        add_vec(1, 7'b100_0010, 31, 5, 3, 1, 1, 9, 9);
        add_vec(0, 7'b100_0010, 31, 5, 3, 0, 1, 9, 9);
        add_vec(0, 7'b100_0010, 31, 5, 3, 0, 1, 9, 9);
        add_vec(0, 7'b100_0010, 31, 5, 3, 0, 1, 9, 9);
        add_vec(0, 7'b100_0010, 31, 5, 3, 0, 1, 9, 9);
        add_vec(0, 7'b100_0010, 31, 5, 3, 0, 0, 9, 9);
        // dead_time=0: immediate refire at the same key
        add_vec(1, 7'b100_0010, 15, 0, 3, 1, 0, 10, 9);
        add_vec(1, 7'b100_0010, 15, 0, 3, 1, 0, 11, 9);
        add_vec(1, 7'b100_0010, 15, 0, 3, 1, 0, 12, 9);
        // dead_time changed mid-zone keeps the loaded duration
        add_vec(1, 7'b100_0010,  5, 5, 3, 1, 1, 13, 9);
        add_vec(0, 7'b100_0010,  5, 1, 3, 0, 1, 13, 9);
        add_vec(0, 7'b100_0010,  5, 1, 3, 0, 1, 13, 9);
        add_vec(0, 7'b100_0010,  5, 1, 3, 0, 1, 13, 9);
        add_vec(0, 7'b100_0010,  5, 1, 3, 0, 1, 13, 9);
        add_vec(0, 7'b100_0010,  5, 1, 3, 0, 0, 13, 9);

        @(posedge clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(i);
        end

        // saturation: 65537 back-to-back fires
        best_vld = 1'b1; best_pat = 7'b111_1111; best_key = 5'd7;
        best_carry = 12'hABC; dead_time = 4'd0; dead_zone = 3'd0;
        repeat (65537) @(posedge clock);
        #1;
        check("sat_clct_cnt", 64'(clct_cnt), 64'hFFFF);
        check("sat_blank_cnt", 64'(blank_cnt), 64'd9);
        check("sat_busy", 64'(busy), 64'd0);

        // enter DEAD, then reset asynchronously mid-zone
        best_key = 5'd8; dead_time = 4'd5; dead_zone = 3'd2;
        @(posedge clock);
        #1;
        check("dead_busy", 64'(busy), 64'd1);
        best_vld = 1'b0;
        @(posedge clock);
        #2;
        global_reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(actual_word()), 64'd0);
        check("async_reset_state", 64'(fsm_state), 64'd0);
        #3;
        global_reset_n = 1'b1;

        // first candidate after release, same key as the old zone, must fire
        best_vld = 1'b1; best_pat = 7'b100_0010; best_key = 5'd8;
        best_carry = 12'h123; dead_time = 4'd5; dead_zone = 3'd2;
        @(posedge clock);
        #1;
        check("post_reset_fire", 64'({clct_vld, clct_key, clct_carry, busy, clct_cnt, blank_cnt}),
              64'({1'b1, 5'd8, 12'h123, 1'b1, 16'd1, 16'd0}));
        best_vld = 1'b0;
        @(posedge clock);
        #1;
        check("pulse_one_clock", 64'({clct_vld, clct_key}), 64'({1'b0, 5'd8}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
